// File: rtl/lenet_pkg.sv
// Shared constants and types for the LeNet layer-3 pooling sequencer.
package lenet_pkg;

  localparam int unsigned L3_NUM_MAPS     = 16;
  localparam int unsigned L3_MAP_SIZE     = 25;
  localparam int unsigned L3_ADDR_WIDTH   = 12;
  localparam int unsigned POOL_GAP_CYCLES = 2;
  localparam int unsigned POOL_TIMEOUT    = 511;
  localparam int unsigned POOL_CNT_WIDTH  = 10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_WAIT_SRC,
    ST_RUN,
    ST_GAP,
    ST_DONE
  } pool_sched_state_t;

endpackage

// File: rtl/sched_timeout_cnt.sv
// Loadable saturating down-counter; shared by the RUN watchdog and the GAP timer.
module sched_timeout_cnt #(
  parameter int unsigned WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  output logic             expired_c
);

  logic [WIDTH-1:0] count;

  // Clear beats load beats decrement; the count sticks at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - WIDTH'(1);
    end
  end

  assign expired_c = (count == '0);

endmodule

// File: rtl/pool3_scheduler.sv
// Walks the 2x2 max-pool engine across every output map of layer 3.
module pool3_scheduler
  import lenet_pkg::*;
#(
  parameter int unsigned NUM_MAPS   = L3_NUM_MAPS,
  parameter int unsigned MAP_SIZE   = L3_MAP_SIZE,
  parameter int unsigned ADDR_WIDTH = L3_ADDR_WIDTH,
  parameter int unsigned GAP_CYCLES = POOL_GAP_CYCLES,
  parameter int unsigned TIMEOUT    = POOL_TIMEOUT
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic                        abort,
  input  logic                        src_valid,
  input  logic                        pool_done,
  output logic                        cal_en,
  output logic [ADDR_WIDTH-1:0]       base_position,
  output logic [$clog2(NUM_MAPS)-1:0] map_idx,
  output logic                        src_ack,
  output logic                        busy,
  output logic                        layer_done,
  output logic                        err
);

  localparam int unsigned IDX_W = $clog2(NUM_MAPS);
  localparam int unsigned CNT_W = POOL_CNT_WIDTH;
  // Loaded with N-1 so the expired flag is seen in the N-th cycle of the state.
  localparam logic [CNT_W-1:0] RUN_LOAD = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_MAPS - 1);

  pool_sched_state_t state_q, state_d;

  logic                  cal_en_d, src_ack_d, busy_d, layer_done_d, err_d;
  logic [ADDR_WIDTH-1:0] base_d;
  logic [IDX_W-1:0]      idx_d;
  logic                  cnt_clr, cnt_load, cnt_en, cnt_expired_c;
  logic [CNT_W-1:0]      cnt_load_val;

  sched_timeout_cnt #(.WIDTH(CNT_W)) u_cnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (cnt_clr),
    .load      (cnt_load),
    .load_val  (cnt_load_val),
    .en        (cnt_en),
    .expired_c (cnt_expired_c)
  );

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      cal_en        <= 1'b0;
      base_position <= '0;
      map_idx       <= '0;
      src_ack       <= 1'b0;
      busy          <= 1'b0;
      layer_done    <= 1'b0;
      err           <= 1'b0;
    end else begin
      state_q       <= state_d;
      cal_en        <= cal_en_d;
      base_position <= base_d;
      map_idx       <= idx_d;
      src_ack       <= src_ack_d;
      busy          <= busy_d;
      layer_done    <= layer_done_d;
      err           <= err_d;
    end
  end

  // Next state and next output values; abort overrides every state.
  always_comb begin
    state_d      = state_q;
    cal_en_d     = 1'b0;
    src_ack_d    = 1'b0;
    layer_done_d = 1'b0;
    err_d        = err;
    base_d       = base_position;
    idx_d        = map_idx;
    cnt_clr      = 1'b0;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cnt_en       = 1'b0;

    if (abort) begin
      state_d = ST_IDLE;
      cnt_clr = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d = ST_SETUP;
            idx_d   = '0;
            base_d  = '0;
            err_d   = 1'b0;
          end
        end
        ST_SETUP: begin
          state_d = ST_WAIT_SRC;
        end
        ST_WAIT_SRC: begin
          if (src_valid) begin
            state_d      = ST_RUN;
            cal_en_d     = 1'b1;
            cnt_load     = 1'b1;
            cnt_load_val = RUN_LOAD;
          end
        end
        ST_RUN: begin
          // A late pool_done still counts as success even on the watchdog's last cycle.
          if (pool_done) begin
            state_d      = ST_GAP;
            src_ack_d    = 1'b1;
            cnt_load     = 1'b1;
            cnt_load_val = GAP_LOAD;
          end else if (cnt_expired_c) begin
            state_d      = ST_GAP;
            err_d        = 1'b1;
            cnt_load     = 1'b1;
            cnt_load_val = GAP_LOAD;
          end else begin
            cal_en_d = 1'b1;
            cnt_en   = 1'b1;
          end
        end
        ST_GAP: begin
          cnt_en = 1'b1;
          // Leave only once the engine has dropped pool_done, so its counters are clear.
          if (cnt_expired_c && !pool_done) begin
            if (map_idx == LAST_IDX) begin
              state_d      = ST_DONE;
              layer_done_d = 1'b1;
            end else begin
              state_d = ST_SETUP;
              idx_d   = map_idx + IDX_W'(1);
              base_d  = base_position + ADDR_WIDTH'(MAP_SIZE);
            end
          end
        end
        ST_DONE: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    busy_d = (state_d != ST_IDLE);
  end

endmodule

// File: tb/tb_pool3_scheduler.sv
// Directed bench for pool3_scheduler with a small pooling-engine model.
module tb_pool3_scheduler;

  logic        clk = 1'b0;
  logic        rst_n, start, abort, src_valid;
  logic        pool_done = 1'b0;
  logic        cal_en, src_ack, busy, layer_done, err;
  logic [11:0] base_position;
  logic [3:0]  map_idx;

  int errors = 0;
  int checks = 0;

  // Engine model knobs: done_delay=0 means pool_done never rises.
  int done_delay = 110;
  int hold_after = 0;
  int run_cnt    = 0;
  int hold_cnt   = 0;

  // Monitor tallies.
  int          ack_cnt  = 0;
  int          ld_cnt   = 0;
  int          rise_cnt = 0;
  int          viol     = 0;
  int          base_log [256];
  logic        prev_cal  = 1'b0;
  logic        prev_ld   = 1'b0;
  logic [11:0] prev_base = '0;

  int a0, l0, r0, n, calhi;
  bit hit;

  pool3_scheduler dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .abort         (abort),
    .src_valid     (src_valid),
    .pool_done     (pool_done),
    .cal_en        (cal_en),
    .base_position (base_position),
    .map_idx       (map_idx),
    .src_ack       (src_ack),
    .busy          (busy),
    .layer_done    (layer_done),
    .err           (err)
  );

  always #5 clk = ~clk;

  // Engine: raise pool_done done_delay cycles into cal_en, hold it hold_after cycles past cal_en falling.
  always @(negedge clk) begin
    if (cal_en) begin
      run_cnt++;
      hold_cnt = hold_after;
      if (done_delay != 0 && run_cnt >= done_delay) pool_done = 1'b1;
    end else begin
      run_cnt = 0;
      if (pool_done) begin
        if (hold_cnt > 0) hold_cnt--;
        else pool_done = 1'b0;
      end
    end
  end

  // Monitor: pulse counts, base log at each cal_en rise, protocol invariants.
  always @(posedge clk) begin
    #1;
    if (src_ack) ack_cnt++;
    if (layer_done) ld_cnt++;
    if (cal_en && !prev_cal) begin
      base_log[rise_cnt % 256] = int'(base_position);
      if (base_position != prev_base) viol++;
      rise_cnt++;
    end
    if (cal_en && prev_cal && base_position != prev_base) viol++;
    if (layer_done && prev_ld) viol++;
    if (prev_ld && busy) viol++;
    prev_cal  = cal_en;
    prev_ld   = layer_done;
    prev_base = base_position;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic logic probe(input int which);
    case (which)
      0:       return cal_en;
      1:       return layer_done;
      default: return logic'(int'(map_idx) == which - 10);
    endcase
  endfunction

  task automatic wait_for(input string tag, input int which, input logic val, input int limit);
    hit = 1'b0;
    for (int i = 0; i < limit && !hit; i++) begin
      if (probe(which) === val) hit = 1'b1;
      else tick();
    end
    chk(tag, 32'(hit), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; src_valid = 1'b0;
    repeat (3) tick();
    chk("rst_cal_en", 32'(cal_en), 0);
    chk("rst_base", 32'(base_position), 0);
    chk("rst_map_idx", 32'(map_idx), 0);
    chk("rst_src_ack", 32'(src_ack), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_layer_done", 32'(layer_done), 0);
    chk("rst_err", 32'(err), 0);
    rst_n = 1'b1;
    tick();
    chk("idle_busy", 32'(busy), 0);

    // Full layer, src_valid tied high.
    src_valid = 1'b1;
    a0 = ack_cnt; l0 = ld_cnt; r0 = rise_cnt;
    start = 1'b1; tick(); start = 1'b0;
    chk("t1_busy_t1", 32'(busy), 1);
    chk("t1_cal_t1", 32'(cal_en), 0);
    tick();
    chk("t1_cal_t2", 32'(cal_en), 0);
    tick();
    chk("t1_cal_t3", 32'(cal_en), 1);
    wait_for("t1_wait_layer_done", 1, 1'b1, 3000);
    chk("t1_ack_count", 32'(ack_cnt - a0), 16);
    chk("t1_ld_count", 32'(ld_cnt - l0), 1);
    chk("t1_err", 32'(err), 0);
    chk("t1_last_idx", 32'(map_idx), 15);
    chk("t1_last_base", 32'(base_position), 375);
    for (int k = 0; k < 16; k++) chk($sformatf("t1_base_map%0d", k), 32'(base_log[(r0 + k) % 256]), 32'(25 * k));
    tick();
    chk("t1_busy_after", 32'(busy), 0);
    chk("t1_ld_width", 32'(layer_done), 0);

    // src_valid withheld for 40 cycles at map 3.
    start = 1'b1; tick(); start = 1'b0;
    wait_for("t2_wait_map3", 13, 1'b1, 1000);
    src_valid = 1'b0;
    calhi = 0;
    repeat (40) begin tick(); if (cal_en) calhi++; end
    chk("t2_cal_low", 32'(calhi), 0);
    chk("t2_map_idx", 32'(map_idx), 3);
    chk("t2_base", 32'(base_position), 75);
    chk("t2_busy", 32'(busy), 1);
    src_valid = 1'b1;
    tick();
    chk("t2_cal_rise", 32'(cal_en), 1);

    // Abort in RUN of map 7.
    wait_for("t3_wait_map7", 17, 1'b1, 2000);
    wait_for("t3_wait_run7", 0, 1'b1, 20);
    repeat (10) tick();
    a0 = ack_cnt; l0 = ld_cnt;
    abort = 1'b1; tick(); abort = 1'b0;
    chk("t3_abort_cal", 32'(cal_en), 0);
    chk("t3_abort_busy", 32'(busy), 0);
    chk("t3_abort_ld", 32'(layer_done), 0);
    repeat (3) tick();
    chk("t3_abort_no_ack", 32'(ack_cnt - a0), 0);
    chk("t3_abort_no_ld", 32'(ld_cnt - l0), 0);

    // Restart with a silent engine: watchdog on map 0.
    done_delay = 0;
    start = 1'b1; tick(); start = 1'b0;
    chk("t4_restart_base", 32'(base_position), 0);
    chk("t4_restart_idx", 32'(map_idx), 0);
    wait_for("t4_wait_run0", 0, 1'b1, 20);
    a0 = ack_cnt;
    n = 0;
    while (cal_en && n < 600) begin n++; tick(); end
    chk("t4_run_cycles", 32'(n), 511);
    chk("t4_err_set", 32'(err), 1);
    chk("t4_no_ack_pulse", 32'(src_ack), 0);
    chk("t4_no_ack_count", 32'(ack_cnt - a0), 0);
    done_delay = 110;
    wait_for("t4_wait_run1", 0, 1'b1, 20);
    chk("t4_map1_base", 32'(base_position), 25);
    chk("t4_map1_idx", 32'(map_idx), 1);

    // start during RUN is ignored and err stays sticky.
    hold_after = 5;
    start = 1'b1; tick(); start = 1'b0;
    chk("t5_ign_idx", 32'(map_idx), 1);
    chk("t5_ign_cal", 32'(cal_en), 1);
    chk("t5_err_sticky", 32'(err), 1);

    // pool_done held 5 cycles past cal_en falling delays the next SETUP.
    wait_for("t6_wait_fall1", 0, 1'b0, 200);
    calhi = 0;
    repeat (5) begin tick(); if (cal_en) calhi++; end
    chk("t6_hold_cal_low", 32'(calhi), 0);
    chk("t6_hold_idx", 32'(map_idx), 1);
    tick();
    chk("t6_next_idx", 32'(map_idx), 2);
    chk("t6_next_base", 32'(base_position), 50);
    hold_after = 0;
    tick(); tick();
    chk("t6_next_cal", 32'(cal_en), 1);

    // Asynchronous reset in GAP of map 2.
    wait_for("t7_wait_fall2", 0, 1'b0, 200);
    chk("t7_ack_pulse", 32'(src_ack), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t7_rst_cal_en", 32'(cal_en), 0);
    chk("t7_rst_base", 32'(base_position), 0);
    chk("t7_rst_idx", 32'(map_idx), 0);
    chk("t7_rst_src_ack", 32'(src_ack), 0);
    chk("t7_rst_busy", 32'(busy), 0);
    chk("t7_rst_ld", 32'(layer_done), 0);
    chk("t7_rst_err", 32'(err), 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // pool_done on the watchdog's final cycle counts as success.
    done_delay = 511;
    start = 1'b1; tick(); start = 1'b0;
    wait_for("t8_wait_run0", 0, 1'b1, 20);
    n = 0;
    while (cal_en && n < 600) begin n++; tick(); end
    chk("t8_run_cycles", 32'(n), 511);
    chk("t8_ack", 32'(src_ack), 1);
    chk("t8_no_err", 32'(err), 0);
    abort = 1'b1; tick(); abort = 1'b0;
    tick();
    chk("t8_abort_busy", 32'(busy), 0);

    chk("invariants", 32'(viol), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
